// File: rtl/local_field_accum.sv
// Local field accumulator: sweeps the ternary weight RAM and spin store,
// summing w[j]*s[j] over j != self_idx into one signed field per start.
module local_field_accum #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_NEURON = 1024,
    parameter int ACC_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_active,
    input  logic [ADDR_WIDTH-1:0] self_idx,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  spin_in,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  field
);

    localparam int NA_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state, state_n;

    logic [NA_W-1:0]       num_lat;
    logic [ADDR_WIDTH-1:0] self_lat;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  term;
    logic [ACC_WIDTH-1:0]  sum;
    logic [NA_W-1:0]       num_clamp;
    logic                  w_pos, w_neg;
    logic                  t_plus, t_minus;
    logic                  excl;
    logic                  last;

    // Out-of-range counts are illegal; clamping keeps the sweep bounded anyway
    assign num_clamp = (num_active > NA_W'(NUM_NEURON)) ?
                       NA_W'(NUM_NEURON) : num_active;

    assign w_pos   = (w_in == DATA_WIDTH'(1));
    assign w_neg   = (w_in == DATA_WIDTH'(3));
    assign t_plus  = (w_pos & spin_in) | (w_neg & ~spin_in);
    assign t_minus = (w_pos & ~spin_in) | (w_neg & spin_in);
    assign excl    = (rd_addr == self_lat);

    always_comb begin
        term = '0;
        if (!excl && t_plus)
            term = ACC_WIDTH'(1);
        else if (!excl && t_minus)
            term = '1;
    end

    assign sum  = acc + term;
    assign last = ({1'b0, rd_addr} == (num_lat - NA_W'(1)));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = (num_clamp == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (last)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rd_addr  <= '0;
            num_lat  <= '0;
            self_lat <= '0;
            acc      <= '0;
            field    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_lat  <= num_clamp;
                        self_lat <= self_idx;
                        acc      <= '0;
                        rd_addr  <= '0;
                        if (num_clamp == '0)
                            field <= '0;
                    end
                end
                ACCUM: begin
                    acc <= sum;
                    // field only moves at sweep end, never shows partials
                    if (last)
                        field <= sum;
                    else
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_local_field_accum.sv
// Directed bench for local_field_accum: RAM/spin store modelled as arrays,
// expected fields and latencies hand-computed per scenario.
module tb_local_field_accum;

    logic        clk;
    logic        reset_l;
    logic        start;
    logic [10:0] num_active;
    logic [9:0]  self_idx;
    logic [9:0]  rd_addr;
    logic [1:0]  w_in;
    logic        spin_in;
    logic        busy;
    logic        done;
    logic [11:0] field;

    logic [1:0]  w_mem [1024];
    logic        s_mem [1024];

    int errors;
    int checks;

    local_field_accum dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .start      (start),
        .num_active (num_active),
        .self_idx   (self_idx),
        .rd_addr    (rd_addr),
        .w_in       (w_in),
        .spin_in    (spin_in),
        .busy       (busy),
        .done       (done),
        .field      (field)
    );

    assign w_in    = w_mem[rd_addr];
    assign spin_in = s_mem[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill(input logic [1:0] w, input logic s);
        for (int i = 0; i < 1024; i++) begin
            w_mem[i] = w;
            s_mem[i] = s;
        end
    endtask

    task automatic pulse_start(input logic [10:0] na, input logic [9:0] si);
        @(posedge clk);
        #1;
        start      = 1'b1;
        num_active = na;
        self_idx   = si;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        int cyc;
        reset_l = 1'b0;
        start   = 1'b0;
        num_active = '0;
        self_idx   = '0;
        fill(2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || field !== 12'd0 || rd_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b field=%0d rd_addr=%0d, want all 0",
                     busy, done, field, rd_addr);
        end
        reset_l = 1'b1;
        cyc = 0;
    endtask

    task automatic test_full_pos;
        int cyc;
        fill(2'b01, 1'b1);
        pulse_start(11'd1024, 10'd5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_pos_busy: busy=%b want 1", busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 1024 || done !== 1'b1) begin
            errors++;
            $display("FAIL full_pos_latency: cycles=%0d done=%b want 1024/1", cyc, done);
        end
        checks++;
        if (field !== 12'd1023) begin
            errors++;
            $display("FAIL full_pos_field: got %0d want 1023", $signed(field));
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_addr !== 10'd1023) begin
            errors++;
            $display("FAIL full_pos_after: done=%b busy=%b rd_addr=%0d want 0/0/1023",
                     done, busy, rd_addr);
        end
    endtask

    task automatic test_full_neg;
        int cyc;
        fill(2'b11, 1'b1);
        pulse_start(11'd1024, 10'd1023);
        wait_done(cyc);
        checks++;
        // -1023 in 12-bit two's complement
        if (cyc !== 1024 || field !== 12'hC01) begin
            errors++;
            $display("FAIL full_neg: cycles=%0d field=%0d want 1024/-1023",
                     cyc, $signed(field));
        end
    endtask

    task automatic test_small;
        int cyc;
        fill(2'b00, 1'b0);
        w_mem[0] = 2'b01; s_mem[0] = 1'b0;
        w_mem[1] = 2'b11; s_mem[1] = 1'b0;
        w_mem[2] = 2'b10; s_mem[2] = 1'b1;
        w_mem[3] = 2'b00; s_mem[3] = 1'b1;
        pulse_start(11'd4, 10'd7);
        wait_done(cyc);
        checks++;
        if (cyc !== 4 || field !== 12'd0) begin
            errors++;
            $display("FAIL small_a: cycles=%0d field=%0d want 4/0", cyc, $signed(field));
        end
        w_mem[0] = 2'b01; s_mem[0] = 1'b1;
        pulse_start(11'd4, 10'd7);
        checks++;
        if (field !== 12'd0) begin
            errors++;
            $display("FAIL small_hold: field=%0d want 0 mid-sweep", $signed(field));
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 4 || field !== 12'd2) begin
            errors++;
            $display("FAIL small_b: cycles=%0d field=%0d want 4/2", cyc, $signed(field));
        end
    endtask

    task automatic test_zero;
        int cyc;
        pulse_start(11'd0, 10'd0);
        wait_done(cyc);
        checks++;
        if (cyc !== 0 || done !== 1'b1 || field !== 12'd0 || rd_addr !== 10'd0) begin
            errors++;
            $display("FAIL zero_len: cycles=%0d done=%b field=%0d rd_addr=%0d want 0/1/0/0",
                     cyc, done, $signed(field), rd_addr);
        end
    endtask

    task automatic test_start_busy;
        int cyc;
        int ndone;
        fill(2'b01, 1'b1);
        pulse_start(11'd8, 10'd2);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == 3);
            if (cyc == 3) begin
                num_active = 11'd3;
                self_idx   = 10'd0;
            end
        end
        start = 1'b0;
        checks++;
        if (cyc !== 8 || field !== 12'd7) begin
            errors++;
            $display("FAIL busy_start: cycles=%0d field=%0d want 8/7", cyc, $signed(field));
        end
        // start raised during the DONE cycle must be dropped
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1)
                ndone++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL done_start: extra busy/done cycles=%0d want 0", ndone);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        fill(2'b01, 1'b0);
        pulse_start(11'd16, 10'd4);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset_l = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || field !== 12'd0 || rd_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b field=%0d rd_addr=%0d want all 0",
                     busy, done, $signed(field), rd_addr);
        end
        #2;
        reset_l = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1)
                cyc++;
        end
        checks++;
        if (cyc !== 0) begin
            errors++;
            $display("FAIL reset_nodone: done pulses=%0d want 0", cyc);
        end
        pulse_start(11'd16, 10'd4);
        wait_done(cyc);
        checks++;
        // 15 terms of -1 -> -15 in 12 bits
        if (cyc !== 16 || field !== 12'hFF1) begin
            errors++;
            $display("FAIL reset_rerun: cycles=%0d field=%0d want 16/-15",
                     cyc, $signed(field));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_full_pos();
        test_full_neg();
        test_small();
        test_zero();
        test_start_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
